mem_bus_arb: RTL and testbench
==============================

// Module: mem_bus_arb
// PURPOSE
//  Parametrised N-channel memory arbiter between core buses (ch0=ibus, ch1=dbus, ...) and one shared memory port.
//  Adds a req/ready handshake, registered request payload, bus-error timeout and selectable arbitration.
//  Sits in the SoC top between the core and the single pmem/RAM model.
// PARAMETERS
//  NUM_CH   2     number of master channels (1..8)
//  AW       32    address width
//  DW       32    data width (multiple of 8)
//  TIMEOUT  255   cycles waiting on mem_ready before a bus error (1..2^16-1)
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous reset, active-low
//  m_req        in   NUM_CH     per-channel request, held until m_ready
//  m_we         in   NUM_CH     per-channel write enable
//  m_addr       in   NUM_CH*AW  per-channel address, ch i at [i*AW +: AW]
//  m_wdata      in   NUM_CH*DW  per-channel write data
//  m_mask       in   NUM_CH*DW/8 per-channel byte mask
//  m_ready      out  NUM_CH     one-cycle completion pulse to the granted channel
//  m_err        out  NUM_CH     one-cycle error pulse (with m_ready) on timeout
//  m_rdata      out  DW         read data, shared, valid when m_ready[i]
//  mem_req      out  1          memory request
//  mem_we       out  1          memory write enable
//  mem_addr     out  AW         memory address
//  mem_wdata    out  DW         memory write data
//  mem_mask     out  DW/8       memory byte mask
//  mem_rdata    in   DW         memory read data, valid with mem_ready
//  mem_ready    in   1          memory completion, single-cycle
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, all outputs 0, grant=0, rr pointer=0, timeout counter=0.
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if any m_req, pick winner; latch its we/addr/wdata/mask and index; go BUSY. No req: stay.
//  - BUSY: mem_req=1, mem_* driven from registers (stable whole phase). Counter increments per cycle.
//    mem_ready=1: latch mem_rdata, go RESP. Counter reaches TIMEOUT with no mem_ready: set err, rdata=0, go RESP.
//  - RESP: m_ready[grant]=1, m_err[grant]=err for exactly one cycle; m_rdata registered; mem_req=0; go IDLE.
//  - Latency: req seen in IDLE at cycle t -> mem_req at t+1; mem_ready at t+k -> m_ready at t+k+1.
//    Minimum turnaround 3 cycles/transaction (mem_ready same cycle as first mem_req).
//  - m_rdata holds last value between transactions; writes return mem_rdata as sampled (don't-care to masters).
//  - mem_ready outside BUSY is ignored; m_req dropped by master mid-BUSY is ignored (transaction completes).
//  - Counter resets to 0 on entry to BUSY; width clog2(TIMEOUT+1), no wrap possible.
//  - Reset asserted mid-transaction: immediate return to IDLE, pending transaction discarded, no m_ready.
//  - Masters must not change payload while req=1 and no ready; arbiter samples only in IDLE.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; search starts at rr_ptr, rr_ptr <= winner+1 (mod NUM_CH) on grant.
//  MEM_ARB_RR_EN undefined: fixed priority, lowest index wins (ibus beats dbus); rr_ptr absent.
// TESTING
//  1 single read ch0 addr=0x80000000, mem_ready 2 cyc after mem_req, mem_rdata=0xDEADBEEF -> m_ready[0] pulse 1 cyc later, m_rdata=0xDEADBEEF, m_err=0.
//  2 ch1 write addr=0x80000100 wdata=0x12345678 mask=4'b0011 -> mem_we=1, mem_addr/wdata/mask match, held stable until mem_ready.
//  3 ch0,ch1 req same cycle, held continuously: RR_EN -> grants 0,1,0,1; no RR_EN -> ch0 every grant, ch1 starved while ch0 held.
//  4 mem_ready never asserts, TIMEOUT=255 -> m_ready[i]=m_err[i]=1 at 256 cyc after mem_req rise, m_rdata=0, back to IDLE.
//  5 rst low during BUSY -> all outputs 0 asynchronously, no m_ready after release; next req served normally.
//  6 stray mem_ready in IDLE/RESP -> no m_ready, FSM unchanged.

Source files
------------

// File: rtl/mem_bus_arb.sv
// -----------------------------------------------------------------------------
// mem_bus_arb
//   N-channel arbiter between core buses (ch0 = ibus, ch1 = dbus, ...) and a
//   single shared memory port. A request accepted in IDLE has its payload
//   registered. The payload is then presented to memory for the whole BUSY
//   phase. The completion is returned to the granted channel as a one-cycle
//   m_ready pulse.
//
//   If memory does not answer within TIMEOUT cycles, the transaction completes
//   with an error: m_err pulses together with m_ready, and the read data is 0.
//
//   Build option:
//     MEM_ARB_RR_EN  defined   -> round-robin arbitration (rotating pointer)
//     MEM_ARB_RR_EN  undefined -> fixed priority, lowest channel index wins
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   m_req      in   [NUM_CH]       per-channel request, held until m_ready
//   m_we       in   [NUM_CH]       per-channel write enable
//   m_addr     in   [NUM_CH*AW]    per-channel address, ch i at [i*AW +: AW]
//   m_wdata    in   [NUM_CH*DW]    per-channel write data
//   m_mask     in   [NUM_CH*DW/8]  per-channel byte mask
//   m_ready    out  [NUM_CH]       one-cycle completion pulse to granted channel
//   m_err      out  [NUM_CH]       one-cycle error pulse (with m_ready)
//   m_rdata    out  [DW]           registered read data, holds between accesses
//   mem_req    out                 memory request (BUSY phase)
//   mem_we     out                 memory write enable
//   mem_addr   out  [AW]           memory address
//   mem_wdata  out  [DW]           memory write data
//   mem_mask   out  [DW/8]         memory byte mask
//   mem_rdata  in   [DW]           memory read data, valid with mem_ready
//   mem_ready  in                  memory completion, single cycle
// -----------------------------------------------------------------------------
module mem_bus_arb #(
   parameter int NUM_CH  = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          m_req,
   input  logic [NUM_CH-1:0]          m_we,
   input  logic [NUM_CH*AW-1:0]       m_addr,
   input  logic [NUM_CH*DW-1:0]       m_wdata,
   input  logic [NUM_CH*(DW/8)-1:0]   m_mask,
   output logic [NUM_CH-1:0]          m_ready,
   output logic [NUM_CH-1:0]          m_err,
   output logic [DW-1:0]              m_rdata,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [AW-1:0]              mem_addr,
   output logic [DW-1:0]              mem_wdata,
   output logic [DW/8-1:0]            mem_mask,
   input  logic [DW-1:0]              mem_rdata,
   input  logic                       mem_ready
);

   localparam int MW = DW / 8;
   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [MW-1:0]   mask_q;
   logic [GW-1:0]   grant_q;
   logic            err_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   rdata_q;

   // Unpack the flat channel buses so the winner can index them directly.
   logic [AW-1:0]   ch_addr  [NUM_CH];
   logic [DW-1:0]   ch_wdata [NUM_CH];
   logic [MW-1:0]   ch_mask  [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign ch_addr[g]  = m_addr[g*AW +: AW];
      assign ch_wdata[g] = m_wdata[g*DW +: DW];
      assign ch_mask[g]  = m_mask[g*MW +: MW];
   end

   logic            req_any;
   logic            timeout_hit;
   logic [GW-1:0]   win;
   logic [GW-1:0]   cand;

   assign req_any     = |m_req;
   assign timeout_hit = (cnt_q == TIMEOUT_C);

`ifdef MEM_ARB_RR_EN
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;

   // Scan from the farthest offset back towards rr_ptr.
   // The requester closest to the pointer is assigned last, so it wins.
   always_comb begin
      win  = rr_ptr_q;
      cand = rr_ptr_q;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         cand = GW'((int'(rr_ptr_q) + i) % NUM_CH);
         if (m_req[cand]) win = cand;
      end
   end

   assign rr_ptr_d = (int'(win) == NUM_CH - 1) ? '0 : win + GW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          rr_ptr_q <= '0;
      else if (state_q == IDLE && req_any) rr_ptr_q <= rr_ptr_d;
   end
`else
   // Descending scan: the lowest requesting index is assigned last and wins.
   always_comb begin
      win  = '0;
      cand = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         cand = GW'(i);
         if (m_req[cand]) win = cand;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of process ordering.
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first, so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_any) state_d = BUSY;
         BUSY:    if (mem_ready || timeout_hit) state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // Request payload, timeout counter and response data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         grant_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_any) begin
               we_q    <= m_we[win];
               addr_q  <= ch_addr[win];
               wdata_q <= ch_wdata[win];
               mask_q  <= ch_mask[win];
               grant_q <= win;
               err_q   <= 1'b0;
               cnt_q   <= '0;
            end
            BUSY: begin
               // A real completion wins over a timeout that expires in the same cycle.
               if (mem_ready) begin
                  rdata_q <= mem_rdata;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are decoded from registers only, so reset clears them immediately.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mask  = '0;
      m_ready   = '0;
      m_err     = '0;
      case (state_q)
         BUSY: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_mask  = mask_q;
         end
         RESP: begin
            m_ready[grant_q] = 1'b1;
            m_err[grant_q]   = err_q;
         end
         default: ;
      endcase
   end

   assign m_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
module tb_mem_bus_arb;

   localparam int NUM_CH  = 2;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int MW      = DW / 8;
   localparam int TIMEOUT = 255;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_CH-1:0]        m_req;
   logic [NUM_CH-1:0]        m_we;
   logic [NUM_CH*AW-1:0]     m_addr;
   logic [NUM_CH*DW-1:0]     m_wdata;
   logic [NUM_CH*MW-1:0]     m_mask;
   logic [NUM_CH-1:0]        m_ready;
   logic [NUM_CH-1:0]        m_err;
   logic [DW-1:0]            m_rdata;
   logic                     mem_req;
   logic                     mem_we;
   logic [AW-1:0]            mem_addr;
   logic [DW-1:0]            mem_wdata;
   logic [MW-1:0]            mem_mask;
   logic [DW-1:0]            mem_rdata;
   logic                     mem_ready;

   mem_bus_arb #(
      .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
      .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_mask(mem_mask),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Stimulus record: lat = cycles from mem_req rise to mem_ready high (1 = same cycle),
   // lat = 0 means memory never answers.
   typedef struct {
      int          ch;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      int          lat;
      logic [31:0] rd;
   } vec_t;

   typedef struct {
      int          ch;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] rdata;
      logic        err;
      int          lat;   // cycles from mem_req rise to m_ready
   } exp_t;

   exp_t        exp_q[$];
   int          ready_cycs[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          rise_cyc = 0;
   logic        mem_req_prev = 1'b0;
   int          model_ptr = 0;

   // memory responder controls
   int          mem_lat = 1;
   int          busy_cnt = 0;
   logic [31:0] rd_word = '0;
   logic        extra_en = 1'b0;
   logic        hold_extra = 1'b0;
   logic        stray_idle = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model: answers after mem_lat cycles of mem_req.
   // It can also inject a stray mem_ready in RESP or IDLE.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (hold_extra) begin
            mem_ready  = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
            hold_extra = 1'b0;
         end else if (stray_idle) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hBAD1_BAD1;
         end else begin
            mem_ready = 1'b0;
            if (rst && mem_req && mem_lat != 0) begin
               busy_cnt++;
               if (busy_cnt == mem_lat) begin
                  mem_ready = 1'b1;
                  mem_rdata = rd_word;
                  busy_cnt  = 0;
                  if (extra_en) hold_extra = 1'b1;
               end
            end else begin
               busy_cnt = 0;
            end
         end
      end
   end

   // Scoreboard monitor, sampled on the falling edge
   initial forever begin
      @(negedge clk);
      if (mem_req && !mem_req_prev) rise_cyc = cyc;
      mem_req_prev = mem_req;
      if (mem_req) begin
         if (exp_q.size() == 0) begin
            check("mem_req_unexpected", 64'(mem_req), 64'(0));
         end else begin
            check("mem_we",    64'(mem_we),    64'(exp_q[0].we));
            check("mem_addr",  64'(mem_addr),  64'(exp_q[0].addr));
            check("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
            check("mem_mask",  64'(mem_mask),  64'(exp_q[0].mask));
         end
      end
      if (m_ready != '0) begin
         ready_cycs.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("m_ready_unexpected", 64'(m_ready), 64'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("m_ready", 64'(m_ready), 64'(1) << e.ch);
            check("m_err",   64'(m_err),   e.err ? (64'(1) << e.ch) : 64'(0));
            check("m_rdata", 64'(m_rdata), 64'(e.rdata));
            check("latency", 64'(cyc - rise_cyc), 64'(e.lat));
         end
         done_cnt++;
      end else if (m_err != '0) begin
         check("m_err_without_ready", 64'(m_err), 64'(0));
      end
   end

   task automatic wait_done(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_cnt < target) check({name, "_no_completion"}, 64'(done_cnt), 64'(target));
   endtask

   task automatic push_exp(input int ch, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           input int lat, input logic [31:0] rd);
      exp_t e;
      e.ch    = ch;
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      e.mask  = mask;
      e.err   = (lat == 0);
      e.rdata = (lat == 0) ? 32'h0 : rd;
      e.lat   = (lat == 0) ? TIMEOUT + 1 : lat;
      exp_q.push_back(e);
   endtask

   task automatic drive_ch(input int ch, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
      m_we[ch]              = we;
      m_addr[ch*AW +: AW]   = addr;
      m_wdata[ch*DW +: DW]  = wdata;
      m_mask[ch*MW +: MW]   = mask;
      m_req[ch]             = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int base;
      mem_lat = v.lat;
      rd_word = v.rd;
      push_exp(v.ch, v.we, v.addr, v.wdata, v.mask, v.lat, v.rd);
      model_ptr = (v.ch + 1) % NUM_CH;
      base = done_cnt;
      drive_ch(v.ch, v.we, v.addr, v.wdata, v.mask);
      wait_done(base + 1, TIMEOUT + 40, name);
      m_req[v.ch] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      vec_t v;
      int   base;
      int   n;
      int   w;

      vecs[0] = '{0, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'hF, 3, 32'hDEAD_BEEF};  // read, ready 2 cyc after mem_req
      vecs[1] = '{1, 1'b1, 32'h8000_0100, 32'h1234_5678, 4'h3, 4, 32'hCAFE_0001};  // write, payload held 4 cycles
      vecs[2] = '{0, 1'b1, 32'h8000_0004, 32'hA5A5_A5A5, 4'hF, 1, 32'h1111_2222};  // minimum turnaround
      vecs[3] = '{1, 1'b0, 32'h8000_0200, 32'h0000_0000, 4'hF, 2, 32'h0F0F_0F0F};
      vecs[4] = '{0, 1'b0, 32'h8000_0010, 32'h0000_0000, 4'hF, 0, 32'hFFFF_FFFF};  // timeout
      vecs[5] = '{1, 1'b0, 32'h8000_0020, 32'h0000_0000, 4'hF, 1, 32'h7654_3210};  // normal after timeout

      rst     = 1'b1;
      m_req   = '0;
      m_we    = '0;
      m_addr  = '0;
      m_wdata = '0;
      m_mask  = '0;
      #2 rst = 1'b0;
      #2;
      check("rst_mem_req",   64'(mem_req),   64'(0));
      check("rst_mem_we",    64'(mem_we),    64'(0));
      check("rst_mem_addr",  64'(mem_addr),  64'(0));
      check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      check("rst_mem_mask",  64'(mem_mask),  64'(0));
      check("rst_m_ready",   64'(m_ready),   64'(0));
      check("rst_m_err",     64'(m_err),     64'(0));
      check("rst_m_rdata",   64'(m_rdata),   64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // table-driven single transactions
      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      repeat (4) @(negedge clk);
      check("rdata_hold_idle", 64'(m_rdata), 64'h7654_3210);

      // stray mem_ready while IDLE
      base = done_cnt;
      stray_idle = 1'b1;
      repeat (5) @(negedge clk);
      stray_idle = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("stray_idle_no_ready", 64'(done_cnt), 64'(base));
      check("stray_idle_rdata",    64'(m_rdata),  64'h7654_3210);
      check("stray_idle_no_req",   64'(mem_req),  64'(0));

      // stray mem_ready during RESP
      extra_en = 1'b1;
      base = done_cnt;
      v = '{0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 2, 32'h2468_ACE0};
      run_vec(v, "stray_resp");
      extra_en = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("stray_resp_rdata",   64'(m_rdata),  64'h2468_ACE0);
      check("stray_resp_one_rdy", 64'(done_cnt), 64'(base + 1));

      // reset asserted mid-BUSY
      mem_lat = 0;
      push_exp(0, 1'b0, 32'h8000_0300, 32'h0, 4'hF, 0, 32'h0);
      drive_ch(0, 1'b0, 32'h8000_0300, 32'h0, 4'hF);
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_seq_busy", 64'(mem_req), 64'(1));
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_mem_req",  64'(mem_req),  64'(0));
      check("async_rst_mem_addr", 64'(mem_addr), 64'(0));
      check("async_rst_m_ready",  64'(m_ready),  64'(0));
      check("async_rst_m_err",    64'(m_err),    64'(0));
      check("async_rst_m_rdata",  64'(m_rdata),  64'(0));
      exp_q.delete();
      m_req = '0;
      model_ptr = 0;
      base = done_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check("no_ready_after_rst", 64'(done_cnt), 64'(base));
      v = '{1, 1'b0, 32'h8000_0600, 32'h0, 4'hF, 2, 32'hC0DE_0006};
      run_vec(v, "post_reset");

      // both channels held continuously for four grants
      repeat (2) @(negedge clk);
      mem_lat = 1;
      rd_word = 32'h1357_9BDF;
      ready_cycs.delete();
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
         w = model_ptr;
         model_ptr = (model_ptr + 1) % NUM_CH;
`else
         w = 0;
`endif
         if (w == 0) push_exp(0, 1'b0, 32'h8000_0400, 32'h0,         4'hF, 1, 32'h1357_9BDF);
         else        push_exp(1, 1'b1, 32'h8000_0500, 32'h55AA_55AA, 4'hC, 1, 32'h1357_9BDF);
      end
      base = done_cnt;
      drive_ch(0, 1'b0, 32'h8000_0400, 32'h0,         4'hF);
      drive_ch(1, 1'b1, 32'h8000_0500, 32'h55AA_55AA, 4'hC);
      wait_done(base + 4, 40, "contend");
      m_req = '0;
      repeat (6) @(negedge clk);
      #1;
      check("contend_grants", 64'(ready_cycs.size()), 64'(4));
      if (ready_cycs.size() >= 4) begin
         for (int k = 1; k < 4; k++)
            check($sformatf("turnaround%0d", k), 64'(ready_cycs[k] - ready_cycs[k-1]), 64'(3));
      end

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
